// File: rtl/lsq_data_mem.sv
// lsq_data_mem -- data-memory responder on the far end of the LSQ memory port.
//
// Takes a one-cycle request pulse (op/addr/store data), waits a fixed LATENCY
// and then completes a byte/half/word load or store against an internal
// word-organised memory, answering with a one-cycle rd_ready or wr_ready.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   op_in         request op (0 = none, bit3 = store; 1..5 LB/LH/LW/LBU/LHU,
//                 9..11 SB/SH/SW, other codes act as LW/SW)
//   addr_in       byte address (upper bits above the memory index alias)
//   wr_data_in    store data, LSB-aligned for SB/SH
//   rd_ready      one-cycle pulse, rd_data valid
//   rd_data       load result extended to 32 bits; holds until the next load
//   wr_ready      one-cycle pulse, store complete
//   busy          a request is in flight
//   err_misalign  pulses with the ready of a misaligned access
//   err_overlap   sticky until rst: a request arrived while busy
module lsq_data_mem #(
  parameter int OP_W    = 4,
  parameter int DEPTH_W = 10,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op_in,
  input  logic [31:0]     addr_in,
  input  logic [31:0]     wr_data_in,
  output logic            rd_ready,
  output logic [31:0]     rd_data,
  output logic            wr_ready,
  output logic            busy,
  output logic            err_misalign,
  output logic            err_overlap
);

  localparam int         DEPTH    = 1 << DEPTH_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DEPTH_W+1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               rd_ready_q, rd_ready_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               wr_ready_q, wr_ready_d;
  logic               err_misalign_q, err_misalign_d;
  logic               err_overlap_q, err_overlap_d;

  logic [31:0] mem [DEPTH];

  logic               req_valid;
  logic               done;
  logic               is_store;
  logic               ld_signed;
  logic               misaligned;
  size_t              size;
  logic [DEPTH_W-1:0] word_idx;
  logic [31:0]        rd_word;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ld_val;
  logic [3:0]         st_be;
  logic [31:0]        st_data;
  logic               mem_we;

  // Address bits above the memory index only alias; they are never stored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_in[31:DEPTH_W+2];

  assign req_valid = (op_in != '0);
  assign word_idx  = addr_q[DEPTH_W+1:2];
  assign done      = (state_q == ST_DONE);

  // ---------------------------------------------------------------------------
  // Op decode of the latched request
  // ---------------------------------------------------------------------------
  always_comb begin
    is_store  = op_q[3];
    ld_signed = 1'b0;
    size      = SZ_WORD;
    if (is_store) begin
      if (op_q == OP_W'(9))       size = SZ_BYTE;
      else if (op_q == OP_W'(10)) size = SZ_HALF;
    end else begin
      case (op_q)
        OP_W'(1): begin size = SZ_BYTE; ld_signed = 1'b1; end
        OP_W'(2): begin size = SZ_HALF; ld_signed = 1'b1; end
        OP_W'(4): size = SZ_BYTE;
        OP_W'(5): size = SZ_HALF;
        default:  size = SZ_WORD;
      endcase
    end
    misaligned = ((size == SZ_HALF) && addr_q[0]) ||
                 ((size == SZ_WORD) && (addr_q[1:0] != 2'b00));
  end

  // ---------------------------------------------------------------------------
  // Load lane select and extension (misaligned loads return zero)
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word = mem[word_idx];
    case (addr_q[1:0])
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      SZ_BYTE: ld_val = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_val = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_val = rd_word;
    endcase
    if (misaligned) ld_val = '0;
  end

  // ---------------------------------------------------------------------------
  // Store lane replication and byte enables
  // ---------------------------------------------------------------------------
  always_comb begin
    case (size)
      SZ_BYTE: begin
        st_data = {4{wdata_q[7:0]}};
        st_be   = 4'b0001 << addr_q[1:0];
      end
      SZ_HALF: begin
        st_data = {2{wdata_q[15:0]}};
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = wdata_q;
        st_be   = 4'b1111;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. cnt_q counts the WAIT cycles still to run, including the
  // current one, so DONE follows the cycle in which it reaches 1.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_DONE;
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. rst gates the write so a reset on the DONE edge wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = (state_q != ST_IDLE);
    mem_we = done && is_store && !misaligned && !rst;
  end

  // ---------------------------------------------------------------------------
  // Request latch and response next-values
  // ---------------------------------------------------------------------------
  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if ((state_q == ST_IDLE) && req_valid) begin
      op_d    = op_in;
      addr_d  = addr_in[DEPTH_W+1:0];
      wdata_d = wr_data_in;
    end
    rd_ready_d     = done && !is_store;
    wr_ready_d     = done && is_store;
    err_misalign_d = done && misaligned;
    rd_data_d      = (done && !is_store) ? ld_val : rd_data_q;
    // Requests seen while not IDLE are dropped, only flagged here.
    err_overlap_d  = err_overlap_q | (busy && req_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_ready_q     <= 1'b0;
      rd_data_q      <= '0;
      wr_ready_q     <= 1'b0;
      err_misalign_q <= 1'b0;
      err_overlap_q  <= 1'b0;
    end else begin
      op_q           <= op_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_ready_q     <= rd_ready_d;
      rd_data_q      <= rd_data_d;
      wr_ready_q     <= wr_ready_d;
      err_misalign_q <= err_misalign_d;
      err_overlap_q  <= err_overlap_d;
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (st_be[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  assign rd_ready     = rd_ready_q;
  assign rd_data      = rd_data_q;
  assign wr_ready     = wr_ready_q;
  assign err_misalign = err_misalign_q;
  assign err_overlap  = err_overlap_q;

endmodule

// File: tb/tb_lsq_data_mem.sv
// Self-checking bench for lsq_data_mem (LATENCY=2). Keeps a byte-addressed
// reference memory and derives load/store results from the access rules.
module tb_lsq_data_mem;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  op_in;
  logic [31:0] addr_in;
  logic [31:0] wr_data_in;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        wr_ready;
  logic        busy;
  logic        err_misalign;
  logic        err_overlap;

  int n_checks;
  int n_fail;

  bit [7:0] mmem [4096];

  lsq_data_mem #(.OP_W(4), .DEPTH_W(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .op_in(op_in), .addr_in(addr_in),
    .wr_data_in(wr_data_in), .rd_ready(rd_ready), .rd_data(rd_data),
    .wr_ready(wr_ready), .busy(busy), .err_misalign(err_misalign),
    .err_overlap(err_overlap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int msize(input logic [3:0] op);
    if (op[3]) return (op == 4'd9) ? 1 : (op == 4'd10) ? 2 : 4;
    return (op == 4'd1 || op == 4'd4) ? 1 : (op == 4'd2 || op == 4'd5) ? 2 : 4;
  endfunction

  function automatic bit mmis(input logic [3:0] op, input logic [31:0] a);
    int s;
    s = msize(op);
    return (s == 2 && a[0]) || (s == 4 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] mload(input logic [3:0] op, input logic [31:0] a);
    int s;
    logic [31:0] v;
    s = msize(op);
    v = '0;
    if (mmis(op, a)) return '0;
    for (int i = 0; i < s; i++) v = v | (32'(mmem[(int'(a[11:0]) + i) & 12'hFFF]) << (8 * i));
    if (op == 4'd1 && v[7])  v = v | 32'hFFFF_FF00;
    if (op == 4'd2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic void mstore(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    int s;
    s = msize(op);
    if (mmis(op, a)) return;
    for (int i = 0; i < s; i++) mmem[(int'(a[11:0]) + i) & 12'hFFF] = 8'(d >> (8 * i));
  endfunction

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic await_ready(output int lat, output int nb, output logic rr, output logic wr,
                             output logic mis, output logic [31:0] rd);
    lat = -1; nb = 0; rr = 1'b0; wr = 1'b0; mis = 1'b0; rd = '0;
    for (int j = 0; j < 20; j++) begin
      if (rd_ready || wr_ready) begin
        lat = j; rr = rd_ready; wr = wr_ready; mis = err_misalign; rd = rd_data;
        return;
      end
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output int nb, output logic rr, output logic wr,
                     output logic mis, output logic [31:0] rd);
    op_in = op; addr_in = a; wr_data_in = d;
    @(negedge clk);
    op_in = '0;
    await_ready(lat, nb, rr, wr, mis, rd);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rd_ready !== 1'b0)     begin n_fail++; $display("FAIL rst_rd_ready: got %b want 0", rd_ready); end
    n_checks++; if (wr_ready !== 1'b0)     begin n_fail++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
    n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (rd_data !== 32'h0)     begin n_fail++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    n_checks++; if (err_misalign !== 1'b0) begin n_fail++; $display("FAIL rst_err_misalign: got %b want 0", err_misalign); end
    n_checks++; if (err_overlap !== 1'b0)  begin n_fail++; $display("FAIL rst_err_overlap: got %b want 0", err_overlap); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_init();
    int lat, nb; logic rr, wr, mis; logic [31:0] rd;
    for (int w = 0; w < 32; w++) begin
      req(4'd11, 32'(w * 4), 32'h0, lat, nb, rr, wr, mis, rd);
      mstore(4'd11, 32'(w * 4), 32'h0);
    end
    n_checks++; if (wr !== 1'b1) begin n_fail++; $display("FAIL init_wr_ready: got %b want 1", wr); end
  endtask

  task automatic test_basic();
    int lat, nb; logic rr, wr, mis; logic [31:0] rd;
    logic [3:0]  lops [4] = '{4'd1, 4'd4, 4'd2, 4'd5};
    logic [31:0] ladr [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] lexp [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
    req(4'd11, 32'h10, 32'hDEAD_BEEF, lat, nb, rr, wr, mis, rd);
    mstore(4'd11, 32'h10, 32'hDEAD_BEEF);
    n_checks++; if (lat !== LAT)   begin n_fail++; $display("FAIL sw_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (nb !== LAT)    begin n_fail++; $display("FAIL sw_busy_cycles: got %0d want %0d", nb, LAT); end
    n_checks++; if (wr !== 1'b1 || rr !== 1'b0) begin n_fail++; $display("FAIL sw_ready: got wr=%b rd=%b want wr=1 rd=0", wr, rr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sw_busy_at_ready: got %b want 0", busy); end
    // back-to-back: issued in the ready cycle
    req(4'd3, 32'h10, 32'h0, lat, nb, rr, wr, mis, rd);
    n_checks++; if (lat !== LAT)   begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
    n_checks++; if (rr !== 1'b1 || wr !== 1'b0) begin n_fail++; $display("FAIL b2b_ready: got rd=%b wr=%b want rd=1 wr=0", rr, wr); end
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_lw_data: got %h want deadbeef", rd); end
    n_checks++; if (err_overlap !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overlap: got %b want 0", err_overlap); end
    for (int k = 0; k < 4; k++) begin
      req(lops[k], ladr[k], 32'h0, lat, nb, rr, wr, mis, rd);
      n_checks++; if (rd !== lexp[k] || rr !== 1'b1) begin n_fail++; $display("FAIL lane_load_%0d: got %h rdy=%b want %h rdy=1", k, rd, rr, lexp[k]); end
    end
    // a store leaves rd_data as it was
    req(4'd11, 32'h14, 32'h0, lat, nb, rr, wr, mis, rd);
    n_checks++; if (rd !== 32'h0000_BEEF) begin n_fail++; $display("FAIL store_keeps_rd_data: got %h want 0000beef", rd); end
  endtask

  task automatic test_sb();
    int lat, nb; logic rr, wr, mis; logic [31:0] rd;
    req(4'd9, 32'h11, 32'h0000_00AA, lat, nb, rr, wr, mis, rd);
    mstore(4'd9, 32'h11, 32'h0000_00AA);
    n_checks++; if (wr !== 1'b1) begin n_fail++; $display("FAIL sb_wr_ready: got %b want 1", wr); end
    req(4'd3, 32'h10, 32'h0, lat, nb, rr, wr, mis, rd);
    n_checks++; if (rd !== 32'hDEAD_AAEF) begin n_fail++; $display("FAIL sb_merge: got %h want deadaaef", rd); end
  endtask

  task automatic test_misalign();
    int lat, nb; logic rr, wr, mis; logic [31:0] rd;
    req(4'd3, 32'h12, 32'h0, lat, nb, rr, wr, mis, rd);
    n_checks++; if (rr !== 1'b1 || lat !== LAT) begin n_fail++; $display("FAIL mis_lw_ready: got rdy=%b lat=%0d want 1/%0d", rr, lat, LAT); end
    n_checks++; if (rd !== 32'h0)  begin n_fail++; $display("FAIL mis_lw_data: got %h want 0", rd); end
    n_checks++; if (mis !== 1'b1)  begin n_fail++; $display("FAIL mis_lw_flag: got %b want 1", mis); end
    req(4'd10, 32'h11, 32'h0000_1234, lat, nb, rr, wr, mis, rd);
    n_checks++; if (wr !== 1'b1 || mis !== 1'b1) begin n_fail++; $display("FAIL mis_sh: got wr=%b mis=%b want 1/1", wr, mis); end
    @(negedge clk);
    n_checks++; if (err_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_width: got %b want 0", err_misalign); end
    req(4'd3, 32'h10, 32'h0, lat, nb, rr, wr, mis, rd);
    n_checks++; if (rd !== 32'hDEAD_AAEF || mis !== 1'b0) begin n_fail++; $display("FAIL mis_sh_suppressed: got %h mis=%b want deadaaef/0", rd, mis); end
  endtask

  task automatic test_overlap();
    int lat, nb, nw, nr; logic rr, wr, mis; logic [31:0] rd;
    nw = 0; nr = 0;
    op_in = 4'd11; addr_in = 32'h30; wr_data_in = 32'h1111_2222;
    @(negedge clk);
    op_in = 4'd11; addr_in = 32'h34; wr_data_in = 32'h9999_9999;
    @(negedge clk);
    op_in = '0;
    for (int j = 0; j < 8; j++) begin
      if (wr_ready) nw++;
      if (rd_ready) nr++;
      @(negedge clk);
    end
    mstore(4'd11, 32'h30, 32'h1111_2222);
    n_checks++; if (nw !== 1 || nr !== 0) begin n_fail++; $display("FAIL ovl_one_ready: got wr=%0d rd=%0d want 1/0", nw, nr); end
    n_checks++; if (err_overlap !== 1'b1) begin n_fail++; $display("FAIL ovl_flag: got %b want 1", err_overlap); end
    req(4'd3, 32'h34, 32'h0, lat, nb, rr, wr, mis, rd);
    n_checks++; if (rd !== mload(4'd3, 32'h34)) begin n_fail++; $display("FAIL ovl_dropped: got %h want %h", rd, mload(4'd3, 32'h34)); end
    req(4'd3, 32'h30, 32'h0, lat, nb, rr, wr, mis, rd);
    n_checks++; if (rd !== 32'h1111_2222) begin n_fail++; $display("FAIL ovl_first_done: got %h want 11112222", rd); end
    n_checks++; if (err_overlap !== 1'b1) begin n_fail++; $display("FAIL ovl_sticky: got %b want 1", err_overlap); end
  endtask

  task automatic test_reset_mid();
    int lat, nb, saw; logic rr, wr, mis; logic [31:0] rd;
    saw = 0;
    op_in = 4'd11; addr_in = 32'h20; wr_data_in = 32'h55;
    @(negedge clk);
    op_in = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (rd_ready || wr_ready || busy || err_misalign) saw++;
      @(negedge clk);
    end
    n_checks++; if (saw !== 0) begin n_fail++; $display("FAIL rmid_quiet: got %0d active cycles want 0", saw); end
    n_checks++; if (rd_data !== 32'h0 || err_overlap !== 1'b0) begin n_fail++; $display("FAIL rmid_cleared: got rd=%h ovl=%b want 0/0", rd_data, err_overlap); end
    req(4'd3, 32'h20, 32'h0, lat, nb, rr, wr, mis, rd);
    n_checks++; if (rd !== 32'h0 || rr !== 1'b1) begin n_fail++; $display("FAIL rmid_no_write: got %h rdy=%b want 0/1", rd, rr); end
    // reset landing on the completion edge
    saw = 0;
    op_in = 4'd11; addr_in = 32'h24; wr_data_in = 32'hCAFE_F00D;
    @(negedge clk);
    op_in = '0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL rdone_pre: got busy=%b wr=%b want 1/0", busy, wr_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (rd_ready || wr_ready || busy) saw++;
      @(negedge clk);
    end
    n_checks++; if (saw !== 0) begin n_fail++; $display("FAIL rdone_quiet: got %0d active cycles want 0", saw); end
    req(4'd3, 32'h24, 32'h0, lat, nb, rr, wr, mis, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rdone_no_write: got %h want 0", rd); end
  endtask

  task automatic test_random();
    int lat, nb; logic rr, wr, mis; logic [31:0] rd;
    logic [3:0] op; logic [31:0] a, d, exp_rd, last_rd; bit st, emis;
    last_rd = 32'h0;
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(1, 15));
      a  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
      d  = $urandom();
      st = op[3];
      emis = mmis(op, a);
      if (st) exp_rd = last_rd; else exp_rd = mload(op, a);
      req(op, a, d, lat, nb, rr, wr, mis, rd);
      if (st) mstore(op, a, d); else last_rd = exp_rd;
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, lat, LAT); end
      n_checks++; if (nb !== LAT)  begin n_fail++; $display("FAIL rnd_busy[%0d]: got %0d want %0d", n, nb, LAT); end
      n_checks++; if (rr !== !st || wr !== st) begin n_fail++; $display("FAIL rnd_ready[%0d] op=%0d: got rd=%b wr=%b want rd=%b wr=%b", n, op, rr, wr, !st, st); end
      n_checks++; if (mis !== emis) begin n_fail++; $display("FAIL rnd_misalign[%0d] op=%0d a=%h: got %b want %b", n, op, a, mis, emis); end
      n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rd_data[%0d] op=%0d a=%h: got %h want %h", n, op, a, rd, exp_rd); end
    end
    n_checks++; if (err_overlap !== 1'b0) begin n_fail++; $display("FAIL rnd_no_overlap: got %b want 0", err_overlap); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; op_in = '0; addr_in = '0; wr_data_in = '0;
    test_reset();
    test_init();
    test_basic();
    test_sb();
    test_misalign();
    test_overlap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
